// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that drives one shared mux select and captures the winning
// requester's word into a single-entry valid/ready output stage.
module rr_mux_arbiter #(
  parameter int switch_bits = 2,
  parameter int data_width  = 8,
  localparam int N          = 1 << switch_bits
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic [N*data_width-1:0] in_data,
  output logic [N-1:0]            ack,
  output logic [switch_bits-1:0]  sel,
  output logic                    o_valid,
  output logic [data_width-1:0]   o_data,
  input  logic                    o_ready
);

  // Handshake: a word moves downstream on any rising edge where o_valid & o_ready.
  // A new word is captured when some requester is asking and the stage is empty
  // or being emptied on the same edge, so back-to-back transfers have no bubble.

  logic [switch_bits-1:0] r_ptr;
  logic [switch_bits-1:0] r_sel;
  logic [N-1:0]           r_ack;
  logic                   r_valid;
  logic [data_width-1:0]  r_data;

  logic [switch_bits-1:0] w_winner;
  logic                   w_load;
  logic [data_width-1:0]  w_mux_out;
  logic [data_width-1:0]  w_slices [N];

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign w_slices[g] = in_data[g*data_width +: data_width];
  end

  // Scan starting at r_ptr; the index sum wraps naturally in switch_bits bits.
  always_comb begin
    logic                   v_found;
    logic [switch_bits-1:0] v_idx;
    v_found  = 1'b0;
    v_idx    = '0;
    w_winner = '0;
    for (int k = 0; k < N; k++) begin
      v_idx = r_ptr + switch_bits'(k);
      if (!v_found && req[v_idx]) begin
        v_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  assign w_load    = (|req) & (~r_valid | o_ready);
  assign w_mux_out = w_slices[w_winner];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_sel   <= '0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_data  <= w_mux_out;
      r_valid <= 1'b1;
      r_sel   <= w_winner;
      r_ptr   <= w_winner + 1'b1;
      r_ack   <= {{(N-1){1'b0}}, 1'b1} << w_winner;
    end else begin
      r_ack <= '0;
      if (r_valid && o_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ack     = r_ack;
  assign sel     = r_sel;
  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model and an expected-word queue.
module tb_rr_mux_arbiter;

  localparam int SB = 2;
  localparam int W  = 8;
  localparam int N  = 1 << SB;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   ack;
  logic [SB-1:0]  sel;
  logic           o_valid;
  logic [W-1:0]   o_data;
  logic           o_ready;

  rr_mux_arbiter #(.switch_bits(SB), .data_width(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .in_data (in_data),
    .ack     (ack),
    .sel     (sel),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int           m_ptr;
  int           m_sel;
  bit           m_valid;
  logic [W-1:0] m_data;
  logic [N-1:0] m_ack;
  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // One clock: predict from pre-edge inputs, advance, then compare outputs.
  task automatic step();
    int win;
    if (!rst && m_valid && o_ready && exp_q.size() > 0)
      chk("pop_word", o_data, exp_q.pop_front());
    if (rst) begin
      m_ptr = 0; m_sel = 0; m_valid = 0; m_data = '0; m_ack = '0;
      exp_q.delete();
    end else if (req != 0 && (!m_valid || o_ready)) begin
      win     = rr_pick(req, m_ptr);
      m_data  = in_data[win*W +: W];
      m_valid = 1;
      m_sel   = win;
      m_ptr   = (win + 1) % N;
      m_ack   = '0;
      m_ack[win] = 1'b1;
      exp_q.push_back(m_data);
    end else begin
      m_ack = '0;
      if (m_valid && o_ready) m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("o_valid", o_valid, m_valid);
    chk("o_data", o_data, m_data);
    chk("sel", sel, m_sel);
    chk("ack", ack, m_ack);
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  initial begin
    rst = 1; req = '1; o_ready = 0; in_data = '0;
    for (int i = 0; i < N; i++) set_slice(i, W'($urandom_range(0, 255)));

    // reset with all requesting
    step(); step();
    chk("t1_valid", o_valid, 0);
    chk("t1_ack", ack, 0);

    // single requester
    rst = 0; req = 4'b0100; set_slice(2, 8'hA5); o_ready = 1;
    step();
    chk("t2_data", o_data, 8'hA5);
    chk("t2_sel", sel, 2);
    chk("t2_ack", ack, 4'b0100);

    // round robin from ptr=0
    rst = 1; step(); rst = 0;
    req = 4'b1111; o_ready = 1;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < N; j++) set_slice(j, W'($urandom_range(0, 255)));
      step();
      chk("t3_sel", sel, i % N);
      chk("t3_valid", o_valid, 1);
    end

    // stall
    rst = 1; step(); rst = 0;
    req = 4'b0011; o_ready = 0; set_slice(0, 8'h11); set_slice(1, 8'h22);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_data", o_data, 8'h11);
      chk("t4_sel", sel, 0);
      if (i > 0) chk("t4_ack", ack, 0);
    end
    o_ready = 1;
    step();
    chk("t4_resume_sel", sel, 1);
    chk("t4_resume_data", o_data, 8'h22);

    // wrap
    req = 4'b1000; step();
    chk("t5_w3", sel, 3);
    req = 4'b1010;
    step(); chk("t5_a", sel, 1);
    step(); chk("t5_b", sel, 3);
    step(); chk("t5_c", sel, 1);

    // mid-operation reset
    o_ready = 0; req = 4'b0001; step();
    chk("t6_hold", o_valid, 1);
    rst = 1; step();
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_data", o_data, 0);
    rst = 0; req = 4'b1000; o_ready = 1; step();
    chk("t6_sel", sel, 3);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 49) == 0);
      req     = N'($urandom_range(0, (1 << N) - 1));
      o_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < N; j++) set_slice(j, W'($urandom_range(0, 255)));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
